// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode types: opcode constants, ALU operation and immediate format enums.
package rv_decode_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  // IMM_NONE yields a zero immediate for formats that carry none.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  // i_alt is funct7[5]; it selects SUB only for register-register ops.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] i_f3,
                                              input logic       i_alt,
                                              input logic       i_is_reg);
    alu_op_t r_op;
    case (i_f3)
      3'b000:  r_op = (i_alt && i_is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  r_op = ALU_SLL;
      3'b010:  r_op = ALU_SLT;
      3'b011:  r_op = ALU_SLTU;
      3'b100:  r_op = ALU_XOR;
      3'b101:  r_op = i_alt ? ALU_SRA : ALU_SRL;
      3'b110:  r_op = ALU_OR;
      default: r_op = ALU_AND;
    endcase
    return r_op;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator; every format sign-extends from instr[31].
module imm_gen
  import rv_decode_pkg::*;
(
  input  logic [31:7] i_instr,
  input  logic [2:0]  i_fmt,
  output logic [31:0] o_imm
);

  imm_fmt_t w_fmt;

  assign w_fmt = imm_fmt_t'(i_fmt);

  always_comb begin
    o_imm = '0;
    case (w_fmt)
      IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: o_imm = {i_instr[31:12], 12'b0};
      IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file selects, control decode, load-use stall and ID/EX register.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [4:0]      read1RegSel,
  output logic [4:0]      read2RegSel,
  input  logic [XLEN-1:0] read1Data,
  input  logic [XLEN-1:0] read2Data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic [2:0]      ex_funct3,
  output logic            ex_alu_src_imm,
  output logic            ex_alu_src_pc,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic            ex_is_store,
  output logic            ex_is_branch,
  output logic            ex_is_jump,
  output logic            ex_illegal
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic        w_f7b5;
  imm_fmt_t    w_fmt;
  alu_op_t     w_alu_op;
  logic        w_src_imm;
  logic        w_src_pc;
  logic        w_has_rd;
  logic        w_load;
  logic        w_store;
  logic        w_branch;
  logic        w_jump;
  logic        w_illegal;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_reg_write;
  logic [31:0] w_imm;
  logic        w_hazard;
  logic        w_adv;
  logic        w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  alu_op_t         r_alu_op;
  logic [2:0]      r_funct3;
  logic            r_src_imm;
  logic            r_src_pc;
  logic            r_reg_write;
  logic            r_load;
  logic            r_store;
  logic            r_branch;
  logic            r_jump;
  logic            r_illegal;

  assign w_opc  = if_instr[6:0];
  assign w_f3   = if_instr[14:12];
  assign w_f7b5 = if_instr[30];

  always_comb begin
    w_fmt     = IMM_NONE;
    w_alu_op  = ALU_ADD;
    w_src_imm = 1'b0;
    w_src_pc  = 1'b0;
    w_has_rd  = 1'b0;
    w_load    = 1'b0;
    w_store   = 1'b0;
    w_branch  = 1'b0;
    w_jump    = 1'b0;
    w_illegal = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        w_fmt     = IMM_U;
        w_alu_op  = ALU_PASSB;
        w_src_imm = 1'b1;
        w_has_rd  = 1'b1;
      end
      OPC_AUIPC: begin
        w_fmt     = IMM_U;
        w_src_imm = 1'b1;
        w_src_pc  = 1'b1;
        w_has_rd  = 1'b1;
      end
      // Jump targets are pc+imm (JAL) or rs1+imm (JALR); rd gets the link.
      OPC_JAL: begin
        w_fmt     = IMM_J;
        w_src_imm = 1'b1;
        w_src_pc  = 1'b1;
        w_jump    = 1'b1;
        w_has_rd  = 1'b1;
      end
      OPC_JALR: begin
        w_fmt     = IMM_I;
        w_src_imm = 1'b1;
        w_jump    = 1'b1;
        w_has_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        w_fmt     = IMM_B;
        w_branch  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        w_fmt     = IMM_I;
        w_src_imm = 1'b1;
        w_load    = 1'b1;
        w_has_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        w_fmt     = IMM_S;
        w_src_imm = 1'b1;
        w_store   = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        w_fmt     = IMM_I;
        w_alu_op  = alu_from_funct3(w_f3, w_f7b5, 1'b0);
        w_src_imm = 1'b1;
        w_has_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OPC_OP: begin
        w_alu_op  = alu_from_funct3(w_f3, w_f7b5, 1'b1);
        w_has_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPC_MISCMEM: begin
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_rs1       = w_use_rs1 ? if_instr[19:15] : 5'd0;
  assign w_rs2       = w_use_rs2 ? if_instr[24:20] : 5'd0;
  assign w_rd        = w_has_rd  ? if_instr[11:7]  : 5'd0;
  assign w_reg_write = w_has_rd && (w_rd != 5'd0);

  assign read1RegSel = w_rs1;
  assign read2RegSel = w_rs2;

  imm_gen u_imm_gen (
    .i_instr (if_instr[31:7]),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  // Unused sources are zero, so a nonzero load rd can never match them.
  assign w_hazard = r_valid && r_load && (r_rd != 5'd0) && if_valid &&
                    ((r_rd == w_rs1) || (r_rd == w_rs2));
  assign w_adv    = !r_valid || ex_ready;
  assign if_ready = w_adv && !w_hazard && !flush && !rst;
  assign w_accept = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_alu_op    <= ALU_ADD;
      r_funct3    <= '0;
      r_src_imm   <= 1'b0;
      r_src_pc    <= 1'b0;
      r_reg_write <= 1'b0;
      r_load      <= 1'b0;
      r_store     <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_pc        <= if_pc;
      r_rs1_data  <= read1Data;
      r_rs2_data  <= read2Data;
      r_imm       <= w_imm;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= w_rd;
      r_alu_op    <= w_alu_op;
      r_funct3    <= w_f3;
      r_src_imm   <= w_src_imm;
      r_src_pc    <= w_src_pc;
      r_reg_write <= w_reg_write;
      r_load      <= w_load;
      r_store     <= w_store;
      r_branch    <= w_branch;
      r_jump      <= w_jump;
      r_illegal   <= w_illegal;
    end else if (w_adv) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid       = r_valid;
  assign ex_pc          = r_pc;
  assign ex_rs1_data    = r_rs1_data;
  assign ex_rs2_data    = r_rs2_data;
  assign ex_imm         = r_imm;
  assign ex_rs1         = r_rs1;
  assign ex_rs2         = r_rs2;
  assign ex_rd          = r_rd;
  assign ex_alu_op      = r_alu_op;
  assign ex_funct3      = r_funct3;
  assign ex_alu_src_imm = r_src_imm;
  assign ex_alu_src_pc  = r_src_pc;
  assign ex_reg_write   = r_reg_write;
  assign ex_is_load     = r_load;
  assign ex_is_store    = r_store;
  assign ex_is_branch   = r_branch;
  assign ex_is_jump     = r_jump;
  assign ex_illegal     = r_illegal;

endmodule
